// File: rtl/mpc_infer_sched.sv
// mpc_infer_sched: fixed-rate sequencer for the quantized MPC network core.
// Each control period it latches r/pos/vel, runs one ap_ctrl inference and
// holds the result on u_out until the next one completes. Overruns and hung
// inferences are counted/flagged.
// Optional output clamp: define MPC_UCLAMP_EN (adds the clamp_hit port).
module mpc_infer_sched #(
    parameter int DW             = 16,
    parameter int PERIOD_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int U_MIN          = -896,
    parameter int U_MAX          = 896
) (
    input  logic                 clk_1,
    input  logic                 ap_rst_n,
    input  logic                 ce_1,
    input  logic                 en,
    input  logic signed [DW-1:0] r,
    input  logic signed [DW-1:0] pos,
    input  logic signed [DW-1:0] vel,
    output logic                 core_start,
    output logic                 core_in_vld,
    output logic signed [DW-1:0] core_r,
    output logic signed [DW-1:0] core_pos,
    output logic signed [DW-1:0] core_vel,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic                 core_idle,
    input  logic signed [DW-1:0] core_out,
    input  logic                 core_out_vld,
    output logic signed [DW-1:0] u_out,
    output logic                 u_vld,
    output logic                 busy,
    output logic [15:0]          overrun_cnt,
    output logic                 timeout_flag,
    input  logic                 clr
`ifdef MPC_UCLAMP_EN
    ,
    output logic                 clamp_hit
`endif
);
    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Reject nonsensical configurations at elaboration.
    if (PERIOD_CYCLES < 2 || TIMEOUT_CYCLES < 1 || U_MIN > U_MAX) begin : g_param_chk
        $error("mpc_infer_sched: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t                 state, state_nx;
    logic [PW-1:0]          pcnt;
    logic [TW-1:0]          wd;
    logic                   tick, launch, overrun, wd_exp;
    logic                   done_evt, abort;
    logic signed [DW-1:0]   res, fin_val, u_nx;
    logic                   res_ok, fin_ok;

    assign tick    = en && (pcnt == PW'(PERIOD_CYCLES - 1));
    assign launch  = (state == IDLE) && tick && core_idle;
    assign overrun = tick && ((state != IDLE) || !core_idle);
    assign wd_exp  = busy && (wd == TW'(TIMEOUT_CYCLES - 1));
    // A result arriving in the done cycle itself must still be used.
    assign fin_val = core_out_vld ? core_out : res;
    assign fin_ok  = core_out_vld || res_ok;

`ifdef MPC_UCLAMP_EN
    localparam logic signed [DW-1:0] UMN = DW'(U_MIN);
    localparam logic signed [DW-1:0] UMX = DW'(U_MAX);
    logic hit_nx;

    // Saturate the core result into [U_MIN, U_MAX].
    always_comb begin
        u_nx   = fin_val;
        hit_nx = 1'b0;
        if (fin_val < UMN) begin
            u_nx   = UMN;
            hit_nx = 1'b1;
        end else if (fin_val > UMX) begin
            u_nx   = UMX;
            hit_nx = 1'b1;
        end
    end

    // Clamp indicator follows every u_out update.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n)                        clamp_hit <= 1'b0;
        else if (ce_1 && done_evt && fin_ok)  clamp_hit <= hit_nx;
    end
`else
    assign u_nx = fin_val;
`endif

    // Period counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n)          pcnt <= '0;
        else if (ce_1) begin
            if (!en || tick)    pcnt <= '0;
            else                pcnt <= pcnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n)  state <= IDLE;
        else if (ce_1)  state <= state_nx;
    end

    // FSM next state; done takes priority over a coincident watchdog expiry.
    always_comb begin
        state_nx = state;
        done_evt = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE:   if (launch) state_nx = LAUNCH;
            LAUNCH: begin
                if (core_ready && core_done) begin
                    state_nx = IDLE;
                    done_evt = 1'b1;
                end else if (wd_exp) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else if (core_ready) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (core_done) begin
                    state_nx = IDLE;
                    done_evt = 1'b1;
                end else if (wd_exp) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs, decoded straight from the state flops.
    always_comb begin
        core_start  = 1'b0;
        core_in_vld = 1'b0;
        busy        = 1'b0;
        case (state)
            LAUNCH: begin
                core_start  = 1'b1;
                core_in_vld = 1'b1;
                busy        = 1'b1;
            end
            WAIT:    busy = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, result capture, watchdog and zero-order-hold output.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            core_r   <= '0;
            core_pos <= '0;
            core_vel <= '0;
            res      <= '0;
            res_ok   <= 1'b0;
            wd       <= '0;
            u_out    <= '0;
            u_vld    <= 1'b0;
        end else if (ce_1) begin
            u_vld <= done_evt;
            if (launch) begin
                core_r   <= r;
                core_pos <= pos;
                core_vel <= vel;
                res_ok   <= 1'b0;
                wd       <= '0;
            end else if (busy) begin
                wd <= wd + 1'b1;
                if (core_out_vld) begin
                    res    <= core_out;
                    res_ok <= 1'b1;
                end
            end
            if (done_evt && fin_ok) u_out <= u_nx;
        end
    end

    // Sticky status; clr beats a same-cycle overrun or abort.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            overrun_cnt  <= '0;
            timeout_flag <= 1'b0;
        end else if (ce_1) begin
            if (clr) begin
                overrun_cnt  <= '0;
                timeout_flag <= 1'b0;
            end else begin
                if (overrun && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
                if (abort) timeout_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mpc_infer_sched.sv
// Bench for mpc_infer_sched: reactive core mock plus an event-level
// reference model (tick times, launch/drop decisions, clamp arithmetic).
module tb_mpc_infer_sched;
    localparam int P = 20;
    localparam int T = 200;

    logic clk = 1'b0;
    logic ap_rst_n = 1'b0, ce_1 = 1'b1, en = 1'b0, clr = 1'b0;
    logic signed [15:0] r = '0, pos = '0, vel = '0;
    logic core_start, core_in_vld, u_vld, busy, timeout_flag;
    logic signed [15:0] core_r, core_pos, core_vel, u_out;
    logic [15:0] overrun_cnt;
    logic core_ready = 1'b0, core_done = 1'b0, core_idle = 1'b1, core_out_vld = 1'b0;
    logic signed [15:0] core_out = '0;
    logic hit_s;

    mpc_infer_sched #(.DW(16), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
        .clk_1(clk), .ap_rst_n(ap_rst_n), .ce_1(ce_1), .en(en),
        .r(r), .pos(pos), .vel(vel),
        .core_start(core_start), .core_in_vld(core_in_vld),
        .core_r(core_r), .core_pos(core_pos), .core_vel(core_vel),
        .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
        .core_out(core_out), .core_out_vld(core_out_vld),
        .u_out(u_out), .u_vld(u_vld), .busy(busy),
        .overrun_cnt(overrun_cnt), .timeout_flag(timeout_flag), .clr(clr)
`ifdef MPC_UCLAMP_EN
        , .clamp_hit(hit_s)
`endif
    );
`ifndef MPC_UCLAMP_EN
    assign hit_s = 1'b0;
`endif

    initial forever #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    int rs_start[$], rs_vld[$], ex_start[$], ex_vld[$];
    int rs_flag;
    logic [15:0] rs_u[$];
    logic rs_hit[$];
    logic [47:0] rs_ops[$], drv[$];
    logic [15:0] mq_val[$], force_q[$];
    bit mq_has[$];
    logic [15:0] model_u = '0;
    bit model_hit = 1'b0;

    // Core mock: ready on the sample start is seen, done mlat samples later.
    int mlat = 5, mcnt = 0;
    bit mock_hang = 0, mock_abort = 0, mbusy = 0, mhas;
    logic [15:0] mval;
    always @(negedge clk) begin
        if (!ap_rst_n || mock_abort) begin
            core_ready = 0; core_done = 0; core_out_vld = 0; core_idle = 1; mbusy = 0;
        end else begin
            core_ready = 0;
            if (mbusy) begin
                if (core_done) begin
                    core_done = 0; core_out_vld = 0; core_idle = 1; mbusy = 0;
                end else if (!mock_hang) begin
                    mcnt--;
                    if (mcnt == 0) begin core_done = 1; core_out_vld = mhas; core_out = mval; end
                end
            end else if (core_start) begin
                core_ready = 1; core_idle = 0; mbusy = 1; mcnt = mlat;
                if (force_q.size() > 0) begin mval = force_q.pop_front(); mhas = 1; end
                else begin mval = 16'($urandom); mhas = ($urandom_range(0, 3) != 0); end
                mq_val.push_back(mval); mq_has.push_back(mhas);
            end
        end
    end

    function automatic logic [15:0] mdl_u(input logic signed [15:0] v);
`ifdef MPC_UCLAMP_EN
        if (int'(v) < -896) return 16'hFC80;
        if (int'(v) > 896)  return 16'h0380;
`endif
        return v;
    endfunction

    function automatic bit mdl_hit(input logic signed [15:0] v);
        return (int'(v) < -896) || (int'(v) > 896);
    endfunction

    task automatic fold_mq();
        foreach (mq_val[k]) if (mq_has[k]) begin model_u = mdl_u(mq_val[k]); model_hit = mdl_hit(mq_val[k]); end
        mq_val.delete(); mq_has.delete();
    endtask

    task automatic drive_ops();
        r = 16'($urandom); pos = 16'($urandom); vel = 16'($urandom);
        drv.push_back({r, pos, vel});
    endtask

    task automatic clear_rec();
        rs_start.delete(); rs_vld.delete(); rs_u.delete(); rs_hit.delete();
        rs_ops.delete(); drv.delete(); mq_val.delete(); mq_has.delete(); rs_flag = -1;
    endtask

    // Sample i is taken after posedge i; en rises before posedge 1, drops before posedge win+1.
    task automatic run_window(input int win, input int total);
        logic prev = 0;
        clear_rec();
        @(negedge clk); en = 1; drive_ops();
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            if (core_start && !prev) begin rs_start.push_back(i); rs_ops.push_back({core_r, core_pos, core_vel}); end
            prev = core_start;
            if (u_vld) begin rs_vld.push_back(i); rs_u.push_back(u_out); rs_hit.push_back(hit_s); end
            if (timeout_flag && rs_flag < 0) rs_flag = i;
            if (i == win) en = 0;
            drive_ops();
        end
    endtask

    // Ticks every P enabled cycles; a tick launches only when both the
    // scheduler and the core are free, otherwise it is a dropped tick.
    task automatic predict(input int lat, input int win, output int ovr);
        int free = 0;
        ex_start.delete(); ex_vld.delete(); ovr = 0;
        for (int t = P; t <= win; t += P) begin
            if (t >= free) begin ex_start.push_back(t); ex_vld.push_back(t + lat + 1); free = t + lat + 2; end
            else ovr++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nvec++;
        if ({u_out, u_vld, busy, core_start, core_in_vld, overrun_cnt, timeout_flag, core_r, hit_s} !== '0) begin
            nerr++; $display("FAIL reset_vals: got u=%h vld=%b busy=%b st=%b ovr=%h to=%b cr=%h, need all 0",
                             u_out, u_vld, busy, core_start, overrun_cnt, timeout_flag, core_r);
        end
        ap_rst_n = 1;
        repeat (3 * P) @(negedge clk);
        nvec++;
        if (core_start !== 1'b0 || busy !== 1'b0) begin
            nerr++; $display("FAIL en_low_idle: start=%b busy=%b, need 0 0", core_start, busy);
        end
    endtask

    task automatic test_schedule(input string name, input int lat, input int win);
        int ovr, n;
        mlat = lat;
        run_window(win, win + lat + 20);
        predict(lat, win, ovr);
        nvec++;
        if (rs_start.size() != ex_start.size()) begin
            nerr++; $display("FAIL %s_nstart: got %0d need %0d", name, rs_start.size(), ex_start.size());
        end
        n = (rs_start.size() < ex_start.size()) ? rs_start.size() : ex_start.size();
        for (int k = 0; k < n; k++) begin
            nvec++;
            if (rs_start[k] != ex_start[k] || rs_ops[k] !== drv[ex_start[k] - 1]) begin
                nerr++; $display("FAIL %s_start%0d: t=%0d ops=%h need t=%0d ops=%h", name, k,
                                 rs_start[k], rs_ops[k], ex_start[k], drv[ex_start[k] - 1]);
            end
        end
        nvec++;
        if (rs_vld.size() != ex_vld.size()) begin
            nerr++; $display("FAIL %s_nvld: got %0d need %0d", name, rs_vld.size(), ex_vld.size());
        end
        n = (rs_vld.size() < ex_vld.size()) ? rs_vld.size() : ex_vld.size();
        if (mq_val.size() < n) n = mq_val.size();
        for (int k = 0; k < n; k++) begin
            if (mq_has[k]) begin model_u = mdl_u(mq_val[k]); model_hit = mdl_hit(mq_val[k]); end
            nvec++;
`ifdef MPC_UCLAMP_EN
            if (rs_vld[k] != ex_vld[k] || rs_u[k] !== model_u || rs_hit[k] !== model_hit) begin
`else
            if (rs_vld[k] != ex_vld[k] || rs_u[k] !== model_u) begin
`endif
                nerr++; $display("FAIL %s_u%0d: t=%0d u=%h hit=%b need t=%0d u=%h hit=%b", name, k,
                                 rs_vld[k], rs_u[k], rs_hit[k], ex_vld[k], model_u, model_hit);
            end
        end
        mq_val.delete(); mq_has.delete();
        nvec++;
        if (overrun_cnt !== 16'(ovr) || busy !== 1'b0) begin
            nerr++; $display("FAIL %s_ovr: cnt=%0d busy=%b need %0d 0", name, overrun_cnt, busy, ovr);
        end
        pulse_clr();
        @(negedge clk);
        nvec++;
        if (overrun_cnt !== 16'd0) begin
            nerr++; $display("FAIL %s_clr: cnt=%0d need 0", name, overrun_cnt);
        end
    endtask

    task automatic test_clamp();
        logic [15:0] eu [3];
        logic eh [3];
        force_q.delete();
        force_q.push_back(16'h0500); force_q.push_back(16'hFB00); force_q.push_back(16'h0010);
`ifdef MPC_UCLAMP_EN
        eu = '{16'h0380, 16'hFC80, 16'h0010}; eh = '{1'b1, 1'b1, 1'b0};
`else
        eu = '{16'h0500, 16'hFB00, 16'h0010}; eh = '{1'b0, 1'b0, 1'b0};
`endif
        mlat = 5;
        run_window(3 * P, 3 * P + 30);
        nvec++;
        if (rs_vld.size() != 3) begin
            nerr++; $display("FAIL clamp_nvld: got %0d need 3", rs_vld.size());
        end
        for (int k = 0; k < 3 && k < rs_vld.size(); k++) begin
            nvec++;
            if (rs_u[k] !== eu[k] || rs_hit[k] !== eh[k]) begin
                nerr++; $display("FAIL clamp%0d: u=%h hit=%b need u=%h hit=%b", k, rs_u[k], rs_hit[k], eu[k], eh[k]);
            end
        end
        fold_mq();
    endtask

    task automatic test_timeout();
        int ovr = 0;
        mock_hang = 1; mlat = 5;
        run_window(P + T, P + T + 20);
        for (int t = 2 * P; t <= P + T; t += P) ovr++;
        nvec++;
        if (rs_start.size() != 1 || rs_flag != P + T || rs_vld.size() != 0) begin
            nerr++; $display("FAIL timeout_evt: starts=%0d flag_t=%0d vlds=%0d need 1 %0d 0",
                             rs_start.size(), rs_flag, rs_vld.size(), P + T);
        end
        nvec++;
        if (core_start !== 1'b0 || busy !== 1'b0 || u_out !== model_u || timeout_flag !== 1'b1) begin
            nerr++; $display("FAIL timeout_hold: st=%b busy=%b u=%h flag=%b need 0 0 %h 1",
                             core_start, busy, u_out, timeout_flag, model_u);
        end
        nvec++;
        if (overrun_cnt !== 16'(ovr)) begin
            nerr++; $display("FAIL timeout_ovr: cnt=%0d need %0d", overrun_cnt, ovr);
        end
        mq_val.delete(); mq_has.delete();
        @(negedge clk); mock_abort = 1; mock_hang = 0;
        repeat (2) @(negedge clk); mock_abort = 0;
        pulse_clr();
        @(negedge clk);
        nvec++;
        if (timeout_flag !== 1'b0 || overrun_cnt !== 16'd0) begin
            nerr++; $display("FAIL timeout_clr: flag=%b cnt=%0d need 0 0", timeout_flag, overrun_cnt);
        end
    endtask

    // Freeze 10 cycles before the first tick, then 4 cycles on the u_vld pulse.
    // Active cycles: 1-3, 14-30 -> tick at 30; 31-36, 41-54 -> tick at 54.
    task automatic test_ce();
        int st[$], vl[$];
        int es[2] = '{30, 54};
        int ev[6] = '{36, 37, 38, 39, 40, 60};
        logic prev = 0;
        clear_rec(); mlat = 5;
        @(negedge clk); en = 1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (core_start && !prev) st.push_back(i);
            prev = core_start;
            if (u_vld) vl.push_back(i);
            if (i == 3) ce_1 = 0;
            if (i == 13) ce_1 = 1;
            if (i == 36) ce_1 = 0;
            if (i == 40) ce_1 = 1;
            if (i == 60) en = 0;
        end
        nvec++;
        if (st.size() != 2 || vl.size() != 6) begin
            nerr++; $display("FAIL ce_counts: starts=%0d vld_samples=%0d need 2 6", st.size(), vl.size());
        end
        for (int k = 0; k < 2 && k < st.size(); k++) begin
            nvec++;
            if (st[k] != es[k]) begin nerr++; $display("FAIL ce_start%0d: t=%0d need %0d", k, st[k], es[k]); end
        end
        for (int k = 0; k < 6 && k < vl.size(); k++) begin
            nvec++;
            if (vl[k] != ev[k]) begin nerr++; $display("FAIL ce_vld%0d: t=%0d need %0d", k, vl[k], ev[k]); end
        end
        fold_mq();
    endtask

    // Launch at 20 (busy until 52) so the tick at 40 is dropped while clr is high.
    task automatic test_clr_race();
        clear_rec(); mlat = 30;
        @(negedge clk); en = 1;
        for (int i = 1; i <= 140; i++) begin
            @(negedge clk);
            if (i == 40) begin
                nvec++;
                if (overrun_cnt !== 16'd0) begin nerr++; $display("FAIL clr_race: cnt=%0d need 0", overrun_cnt); end
            end
            if (i == 80) begin
                nvec++;
                if (overrun_cnt !== 16'd1) begin nerr++; $display("FAIL clr_after: cnt=%0d need 1", overrun_cnt); end
            end
            clr = (i == 39);
            if (i == 100) en = 0;
        end
        fold_mq();
    endtask

    task automatic test_reset_mid();
        clear_rec(); mlat = 5;
        @(negedge clk); en = 1;
        repeat (P + 2) @(negedge clk);
        ap_rst_n = 0;
        #1;
        nvec++;
        if ({u_out, u_vld, busy, core_start, overrun_cnt, timeout_flag, hit_s} !== '0) begin
            nerr++; $display("FAIL reset_mid: u=%h vld=%b busy=%b st=%b ovr=%0d to=%b, need all 0",
                             u_out, u_vld, busy, core_start, overrun_cnt, timeout_flag);
        end
        en = 0; model_u = '0; model_hit = 0;
        repeat (2) @(negedge clk);
        ap_rst_n = 1;
        mq_val.delete(); mq_has.delete();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_schedule("nominal", 5, 5 * P);
        test_schedule("overrun", 30, 10 * P);
        for (int k = 0; k < 3; k++) test_schedule("random", $urandom_range(1, 45), $urandom_range(5 * P, 10 * P));
        test_schedule("en_mid", 5, P + 2);
        test_clamp();
        test_timeout();
        test_ce();
        test_clr_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
